// File: rtl/stim_seq_if.sv
// Stimulus sequencer bus: start/seed/hold in, serial bit plus run status out.
// Direction is named from the sequencer side (master) and its controller (slave).
interface stim_seq_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 16
);
  localparam int CW = $clog2(COUNT + 1);

  logic             start;
  logic [WIDTH-1:0] seed;
  logic             hold;
  logic             a;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bit_cnt;

  modport master (
    input  start, seed, hold,
    output a, valid, busy, done, bit_cnt
  );

  modport slave (
    output start, seed, hold,
    input  a, valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/stim_seq.sv
// One-bit stimulus sequencer: after an accepted start, emits COUNT bits (rotate or Galois LFSR), then a 1-cycle done.
// First bit one cycle after start, done COUNT+1 cycles after start; hold pauses emission cycle-for-cycle.
module stim_seq #(
  parameter int               MODE  = 0,
  parameter int               WIDTH = 8,
  parameter int               COUNT = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic      clock,
  input  logic      reset_n,
  stim_seq_if.master bus
);
  localparam int            CW       = $clog2(COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_step, seed_load;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             a_q, a_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last;
  logic             emit;

  assign last = (bit_cnt_q == CNT_LAST);

  generate
    if (MODE == 0) begin : g_rotate
      assign shreg_step = {shreg_q[0], shreg_q[WIDTH-1:1]};
      assign seed_load  = bus.seed;
    end else begin : g_lfsr
      assign shreg_step = (shreg_q >> 1) ^ (shreg_q[0] ? TAPS : '0);
      // An all-zero LFSR would stick at zero forever.
      assign seed_load  = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
               else if (bus.hold) state_d = PAUSE;
      PAUSE:   if (!bus.hold) state_d = RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving PAUSE emits on that same edge, so each pause cycle costs exactly one cycle.
  always_comb begin
    emit      = ((state_q == RUN) && !last && !bus.hold) ||
                ((state_q == PAUSE) && !bus.hold);
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    a_d       = a_q;
    valid_d   = 1'b0;
    busy_d    = (state_d == RUN) || (state_d == PAUSE);
    done_d    = (state_d == DONE);
    if ((state_q == IDLE) && bus.start) begin
      shreg_d   = seed_load;
      bit_cnt_d = '0;
    end
    if (emit) begin
      a_d       = shreg_q[0];
      valid_d   = 1'b1;
      shreg_d   = shreg_step;
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      a_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      a_q       <= a_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.a       = a_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_stim_seq.sv
// Directed bench for stim_seq: a rotate instance (COUNT=8) and an LFSR instance (COUNT=6)
// driven from a cycle table plus hand-written pause, LFSR and reset sequences.
module tb_stim_seq;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  stim_seq_if #(.WIDTH(8), .COUNT(8)) rot_if ();
  stim_seq_if #(.WIDTH(8), .COUNT(6)) lf_if ();

  stim_seq #(.MODE(0), .WIDTH(8), .COUNT(8), .TAPS(8'hB8)) u_rot (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (rot_if.master)
  );

  stim_seq #(.MODE(1), .WIDTH(8), .COUNT(6), .TAPS(8'hB8)) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (lf_if.master)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       start;
    logic       hold;
    logic [7:0] seed;
    logic       a;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } vec_t;

  vec_t       tbl [11];
  logic [5:0] lf_bits;
  logic [7:0] lf_path [6];
  logic [5:0] rot_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic run_lfsr(input logic [7:0] sd, input string tag);
    lf_if.seed  = sd;
    lf_if.start = 1'b1;
    step();
    lf_if.start = 1'b0;
    chk({tag, ".busy0"}, 32'(lf_if.busy), 1);
    chk({tag, ".cnt0"}, 32'(lf_if.bit_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s.shreg%0d", tag, i), 32'(u_lfsr.shreg_q), 32'(lf_path[i]));
      step();
      chk($sformatf("%s.a%0d", tag, i), 32'(lf_if.a), 32'(lf_bits[i]));
      chk($sformatf("%s.valid%0d", tag, i), 32'(lf_if.valid), 1);
    end
    step();
    chk({tag, ".done"}, 32'(lf_if.done), 1);
    chk({tag, ".busy_end"}, 32'(lf_if.busy), 0);
    chk({tag, ".cnt_end"}, 32'(lf_if.bit_cnt), 6);
    step();
    chk({tag, ".done_clr"}, 32'(lf_if.done), 0);
  endtask

  initial begin
    logic saw_done;

    rot_if.start = 1'b0; rot_if.hold = 1'b0; rot_if.seed = 8'h00;
    lf_if.start  = 1'b0; lf_if.hold  = 1'b0; lf_if.seed  = 8'h00;

    // start, hold, seed | a, valid, busy, done, cnt (outputs after the edge)
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[3]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3};
    tbl[4]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4};
    tbl[5]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5};
    tbl[6]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6};
    tbl[7]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7};
    tbl[8]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd8};
    tbl[9]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8};
    tbl[10] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8};

    lf_bits    = 6'b110001;
    lf_path[0] = 8'h01; lf_path[1] = 8'hB8; lf_path[2] = 8'h5C;
    lf_path[3] = 8'h2E; lf_path[4] = 8'h17; lf_path[5] = 8'hB3;
    rot_tail   = 6'b101001;

    #2;
    chk("rst.rot_a", 32'(rot_if.a), 0);
    chk("rst.rot_valid", 32'(rot_if.valid), 0);
    chk("rst.rot_busy", 32'(rot_if.busy), 0);
    chk("rst.rot_done", 32'(rot_if.done), 0);
    chk("rst.rot_cnt", 32'(rot_if.bit_cnt), 0);
    chk("rst.lf_busy", 32'(lf_if.busy), 0);
    chk("rst.lf_cnt", 32'(lf_if.bit_cnt), 0);
    #10 reset_n = 1'b1;
    step();

    // Unpaused rotate run with an ignored mid-run start and a hold in IDLE.
    for (int i = 0; i < 11; i++) begin
      rot_if.start = tbl[i].start;
      rot_if.hold  = tbl[i].hold;
      rot_if.seed  = tbl[i].seed;
      step();
      chk($sformatf("tbl[%0d].a", i), 32'(rot_if.a), 32'(tbl[i].a));
      chk($sformatf("tbl[%0d].valid", i), 32'(rot_if.valid), 32'(tbl[i].valid));
      chk($sformatf("tbl[%0d].busy", i), 32'(rot_if.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl[%0d].done", i), 32'(rot_if.done), 32'(tbl[i].done));
      chk($sformatf("tbl[%0d].cnt", i), 32'(rot_if.bit_cnt), 32'(tbl[i].cnt));
    end
    rot_if.start = 1'b0;
    rot_if.hold  = 1'b0;
    step();

    run_lfsr(8'h01, "lfsr_s1");
    run_lfsr(8'h00, "lfsr_s0");

    // Pause for 3 cycles after the 2nd bit; hold again on the final bit cycle.
    rot_if.seed  = 8'hA5;
    rot_if.start = 1'b1;
    step();
    rot_if.start = 1'b0;
    step();
    chk("pause.b1", 32'(rot_if.a), 1);
    step();
    chk("pause.b2", 32'(rot_if.a), 0);
    rot_if.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pause.valid_p%0d", i), 32'(rot_if.valid), 0);
      chk($sformatf("pause.a_p%0d", i), 32'(rot_if.a), 0);
      chk($sformatf("pause.busy_p%0d", i), 32'(rot_if.busy), 1);
      chk($sformatf("pause.cnt_p%0d", i), 32'(rot_if.bit_cnt), 2);
    end
    rot_if.hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("pause.valid%0d", i + 3), 32'(rot_if.valid), 1);
      chk($sformatf("pause.a%0d", i + 3), 32'(rot_if.a), 32'(rot_tail[i]));
    end
    rot_if.hold = 1'b1;
    step();
    chk("pause.done", 32'(rot_if.done), 1);
    chk("pause.cnt", 32'(rot_if.bit_cnt), 8);
    rot_if.hold = 1'b0;
    step();
    chk("pause.done_clr", 32'(rot_if.done), 0);

    // Reset after the 4th bit aborts without a done pulse.
    rot_if.start = 1'b1;
    step();
    rot_if.start = 1'b0;
    repeat (4) step();
    chk("abort.cnt_pre", 32'(rot_if.bit_cnt), 4);
    #2 reset_n = 1'b0;
    #1;
    chk("abort.a", 32'(rot_if.a), 0);
    chk("abort.valid", 32'(rot_if.valid), 0);
    chk("abort.busy", 32'(rot_if.busy), 0);
    chk("abort.cnt", 32'(rot_if.bit_cnt), 0);
    saw_done = 1'b0;
    repeat (3) begin
      step();
      if (rot_if.done) saw_done = 1'b1;
    end
    #3 reset_n = 1'b1;
    repeat (10) begin
      step();
      if (rot_if.done) saw_done = 1'b1;
    end
    chk("abort.no_done", 32'(saw_done), 0);

    // Start held high: accepted again in the first IDLE cycle after DONE.
    rot_if.start = 1'b1;
    step();
    chk("restart.busy", 32'(rot_if.busy), 1);
    chk("restart.cnt0", 32'(rot_if.bit_cnt), 0);
    repeat (8) step();
    chk("restart.cnt8", 32'(rot_if.bit_cnt), 8);
    step();
    chk("restart.done", 32'(rot_if.done), 1);
    step();
    chk("restart.idle", 32'(rot_if.busy), 0);
    step();
    chk("restart.rebusy", 32'(rot_if.busy), 1);
    chk("restart.recnt", 32'(rot_if.bit_cnt), 0);
    rot_if.start = 1'b0;
    repeat (11) step();
    chk("restart.final_cnt", 32'(rot_if.bit_cnt), 8);
    chk("restart.final_busy", 32'(rot_if.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
